adder_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one N-bit ripple-carry adder (`nBitRippleCarryAdder`) among four requesters. Each requester presents operands with a level request. The scheduler grants one requester per cycle, routes that requester's operands through the shared adder, and registers the result into a single output slot with valid/ready backpressure. It sits between the operand-producing blocks and the adder datapath, so the design needs only one adder instance.

---
 rtl/adder_rr_scheduler.sv | 107 ++++++++++
 tb/tb_adder_rr_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Four-way round-robin front end for one shared ripple-carry adder; the result is
// registered one cycle after the grant, and a stalled result slot blocks every grant.

module nBitRippleCarryAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[N];
  end

endmodule

module adder_rr_scheduler #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] a_in,
  input  logic [4*N-1:0] b_in,
  input  logic [3:0]     cin_in,
  output logic [3:0]     gnt,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_sum,
  output logic           res_cout,
  output logic [1:0]     res_id
);

  logic [1:0]   ptr;
  logic [1:0]   idx;
  logic [1:0]   win_idx;
  logic         win_found;
  logic         slot_free;
  logic         grant;
  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_sum;
  logic         add_cout;

  assign slot_free = !res_valid || res_ready;

  // Search starts at ptr and wraps naturally through the 2-bit index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    idx       = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign grant = win_found && slot_free && !rst;
  assign gnt   = grant ? (4'b0001 << win_idx) : 4'b0000;

  assign add_a   = a_in[win_idx*N +: N];
  assign add_b   = b_in[win_idx*N +: N];
  assign add_cin = cin_in[win_idx];

  nBitRippleCarryAdder #(.N(N)) u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 2'd0;
      ptr       <= 2'd0;
    end else if (grant) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_id    <= win_idx;
      ptr       <= win_idx + 2'd1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: expected results are queued at grant time
// and checked by an independent monitor when the result is handed off.

module tb_adder_rr_scheduler;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*N-1:0] a_in;
  logic [4*N-1:0] b_in;
  logic [3:0]     cin_in;
  logic [3:0]     gnt;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_sum;
  logic           res_cout;
  logic [1:0]     res_id;

  int total = 0;
  int bad   = 0;

  // Hand-computed {cout, sum} per requester for the operands currently loaded.
  logic [N:0]  exp_res [4];
  logic [10:0] sb[$];

  logic        hold_prev = 1'b0;
  logic [10:0] hold_val;

  adder_rr_scheduler #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] esum, input logic ecout);
    a_in[i*N +: N] = a;
    b_in[i*N +: N] = b;
    cin_in[i]      = c;
    exp_res[i]     = {ecout, esum};
  endtask

  // One cycle: drive, check grant and valid at the negedge, queue the expected result.
  task automatic step(input logic [3:0] r, input logic rdy, input logic [3:0] eg, input logic ev);
    req       = r;
    res_ready = rdy;
    @(negedge clk);
    chk("gnt", {28'd0, gnt}, {28'd0, eg});
    chk("res_valid", {31'd0, res_valid}, {31'd0, ev});
    for (int i = 0; i < 4; i++)
      if (eg[i]) sb.push_back({i[1:0], exp_res[i]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r, input logic rdy);
    rst       = 1'b1;
    req       = r;
    res_ready = rdy;
    @(negedge clk);
    chk("gnt_in_reset", {28'd0, gnt}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_sum", {24'd0, res_sum}, 32'd0);
    chk("rst_cout", {31'd0, res_cout}, 32'd0);
    chk("rst_id", {30'd0, res_id}, 32'd0);
    rst = 1'b0;
  endtask

  // Monitor: pops on each handshake and checks a stalled result stays frozen.
  always @(negedge clk) begin
    if (hold_prev && !rst) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_result", {21'd0, res_id, res_cout, res_sum}, {21'd0, hold_val});
    end
    hold_prev = res_valid && !res_ready && !rst;
    hold_val  = {res_id, res_cout, res_sum};
    if (res_valid === 1'b1 && res_ready === 1'b1 && !rst) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", {21'd0, res_id, res_cout, res_sum}, 32'hFFFF_FFFF);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        chk("res_id", {30'd0, res_id}, {30'd0, e[10:9]});
        chk("res_cout", {31'd0, res_cout}, {31'd0, e[8]});
        chk("res_sum", {24'd0, res_sum}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req       = 4'b0000;
    res_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    cin_in    = '0;
    for (int i = 0; i < 4; i++) exp_res[i] = '0;
    @(posedge clk);
    #1;
    do_reset(4'b1111, 1'b1);

    // Single request: 0x12 + 0x34 = 0x46.
    set_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    step(4'b0001, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Wrap-around: 0xFF + 0x01 + 1 = 0x101.
    set_op(2, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
    step(4'b0100, 1'b1, 4'b0100, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Pointer now at 3: requester 3 beats 0, then 0 follows.
    set_op(3, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    set_op(0, 8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0);
    step(4'b1001, 1'b1, 4'b1000, 1'b0);
    step(4'b0001, 1'b1, 4'b0001, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Fairness from reset with all four requesting.
    do_reset(4'b1111, 1'b1);
    set_op(1, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0);
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0010, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 1'b1);
    step(4'b1111, 1'b1, 4'b0001, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Backpressure: result from 1 stalls three cycles, then handover to 2 without a bubble.
    step(4'b0010, 1'b1, 4'b0010, 1'b0);
    step(4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 1'b0, 4'b0000, 1'b1);
    step(4'b0100, 1'b1, 4'b0100, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Reset with a held result and ptr at 3: result dropped, first grant goes to 0.
    step(4'b0100, 1'b1, 4'b0100, 1'b0);
    do_reset(4'b1111, 1'b0);
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
